// File: rtl/irq_pkg.sv
// irq_pkg: shared sizes, FSM encodings and index decode helper for the IRQ encoder.
package irq_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_CLEAR   = 2'd2;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/prio_enc_8_3.sv
// prio_enc_8_3: fixed-priority encoder, lowest set bit wins; any flags a nonzero input.
module prio_enc_8_3
    import irq_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
    end

    assign any = |vec;
endmodule

// File: rtl/irq_encoder_8_3.sv
// irq_encoder_8_3: captures 8 interrupt requests into a pending vector and presents
// the highest-priority enabled one as a held index until acknowledged.
module irq_encoder_8_3
    import irq_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mask_we,
    input  logic [NUM_REQ-1:0] mask_in,
    input  logic               irq_ack,
    output logic               irq_valid,
    output logic [IDX_W-1:0]   irq_index,
    output logic [NUM_REQ-1:0] pending
);
    logic [1:0]         state;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] rise_q;
    logic [NUM_REQ-1:0] mask;
    logic               armed;
    logic [NUM_REQ-1:0] set_v;
    logic [NUM_REQ-1:0] clr_v;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               ack_take;

    assign ack_take = (state == ST_PRESENT) && irq_ack;
    assign set_v    = EDGE_MODE ? rise_q : req;
    assign clr_v    = ack_take ? idx_onehot(irq_index) : '0;

    prio_enc_8_3 u_prio (
        .vec (pending & mask),
        .idx (win_idx),
        .any (win_any)
    );

    // armed suppresses edge detection on the first edge after reset so a request
    // held high across release is not mistaken for a fresh rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            irq_valid <= 1'b0;
            irq_index <= '0;
            pending   <= '0;
            req_q     <= '0;
            rise_q    <= '0;
            mask      <= '1;
            armed     <= 1'b0;
        end else begin
            req_q   <= req;
            armed   <= 1'b1;
            rise_q  <= armed ? (req & ~req_q) : '0;
            pending <= (pending & ~clr_v) | set_v;
            if (mask_we) mask <= mask_in;
            case (state)
                ST_IDLE: begin
                    irq_valid <= win_any;
                    if (win_any) begin
                        irq_index <= win_idx;
                        state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        state     <= ST_CLEAR;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_encoder_8_3.sv
// tb_irq_encoder_8_3: table-driven and hand-sequenced checks of edge and level
// mode encoders, with a queue of expected presented indices.
module tb_irq_encoder_8_3;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = '0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_in = '0;
    logic       irq_ack = 1'b0;
    logic       irq_valid;
    logic [2:0] irq_index;
    logic [7:0] pending;

    logic [7:0] req_l = '0;
    logic       ack_l = 1'b0;
    logic       valid_l;
    logic [2:0] index_l;
    logic [7:0] pending_l;

    int checks = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic [7:0]  req;
        logic [7:0]  mask;
        int          n;
        logic [23:0] seq;
        logic [7:0]  pend;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    irq_encoder_8_3 #(.EDGE_MODE(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .req(req), .mask_we(mask_we), .mask_in(mask_in),
        .irq_ack(irq_ack), .irq_valid(irq_valid), .irq_index(irq_index), .pending(pending)
    );

    irq_encoder_8_3 #(.EDGE_MODE(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .req(req_l), .mask_we(1'b0), .mask_in(8'hFF),
        .irq_ack(ack_l), .irq_valid(valid_l), .irq_index(index_l), .pending(pending_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!irq_valid && w < 20) begin
            tick();
            w++;
        end
    endtask

    task automatic serve(input int n);
        for (int k = 0; k < n; k++) begin
            wait_valid();
            check("serve_valid", irq_valid, 1);
            if (!irq_valid) begin
                exp_q.delete();
                return;
            end
            check("serve_idx", irq_index, exp_q.pop_front());
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
            check("ack_drops_valid", irq_valid, 0);
            tick();
            check("clear_gap", irq_valid, 0);
        end
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_in = m;
        mask_we = 1'b1;
        tick();
        mask_we = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA0, 8'hFF, 2, 24'o75,       8'h00};
        vecs[1] = '{8'hFF, 8'hFF, 8, 24'o76543210, 8'h00};
        vecs[2] = '{8'h81, 8'hFF, 2, 24'o70,       8'h00};
        vecs[3] = '{8'h12, 8'hFF, 2, 24'o41,       8'h00};
        vecs[4] = '{8'h09, 8'hFE, 1, 24'o3,        8'h01};
        vecs[5] = '{8'h00, 8'hFF, 1, 24'o0,        8'h00};

        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", irq_valid, 0);
        check("rst_index", irq_index, 0);
        check("rst_pending", pending, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // single pulse latency: sampled at edge N, valid at N+2
        req = 8'h04;
        tick();
        req = 8'h00;
        check("lat_n_pending", pending, 8'h00);
        tick();
        check("lat_n1_pending", pending, 8'h04);
        check("lat_n1_valid", irq_valid, 0);
        tick();
        check("lat_n2_valid", irq_valid, 1);
        check("lat_n2_index", irq_index, 3'd2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("lat_ack_valid", irq_valid, 0);
        check("lat_ack_pending", pending, 8'h00);
        tick(2);

        for (int i = 0; i < 6; i++) begin
            set_mask(vecs[i].mask);
            req = vecs[i].req;
            tick();
            req = 8'h00;
            for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].seq[3*k +: 3]);
            serve(vecs[i].n);
            tick(3);
            check("vec_pending", pending, vecs[i].pend);
        end

        // presented index holds while a higher-priority source arrives
        req = 8'h20;
        tick();
        req = 8'h00;
        wait_valid();
        check("hold_idx5", irq_index, 3'd5);
        req = 8'h02;
        tick();
        req = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_valid", irq_valid, 1);
            check("hold_index", irq_index, 3'd5);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        exp_q.push_back(3'd1);
        serve(1);
        tick(2);

        // ack in IDLE must not clear a masked pending bit
        set_mask(8'h00);
        req = 8'h08;
        tick();
        req = 8'h00;
        tick(3);
        check("idle_pending", pending, 8'h08);
        check("idle_valid", irq_valid, 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
        check("idle_ack_ignored", pending, 8'h08);
        set_mask(8'hFF);
        exp_q.push_back(3'd3);
        serve(1);
        tick(2);

        // level mode: one edge less latency, re-present while held
        req_l = 8'h40;
        tick();
        check("lvl_pending", pending_l, 8'h40);
        check("lvl_n_valid", valid_l, 0);
        tick();
        check("lvl_valid", valid_l, 1);
        check("lvl_index", index_l, 3'd6);
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        check("lvl_ack_valid", valid_l, 0);
        check("lvl_set_wins", pending_l, 8'h40);
        tick();
        check("lvl_clear_gap", valid_l, 0);
        tick();
        check("lvl_represent", valid_l, 1);
        check("lvl_represent_idx", index_l, 3'd6);
        req_l = 8'h00;
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        tick();
        check("lvl_final_pending", pending_l, 8'h00);

        // reset mid-present, request held across release
        req = 8'h04;
        tick();
        wait_valid();
        check("pre_rst_valid", irq_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", irq_valid, 0);
        check("mid_rst_index", irq_index, 0);
        check("mid_rst_pending", pending, 0);
        tick();
        rst_n = 1'b1;
        tick(6);
        check("held_req_valid", irq_valid, 0);
        check("held_req_pending", pending, 0);
        req = 8'h00;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
